// File: rtl/median_window_gen.sv
// median_window_gen: column-major streaming 3x3 window generator feeding the median filter.
// Rev 1.0
`default_nettype none

module median_window_gen #(
  parameter int ROW = 430,
  parameter int COL = 554
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_sof,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic signed [31:0] pixel,
  output logic [7:0]         win_0,
  output logic [7:0]         win_1,
  output logic [7:0]         win_2,
  output logic [7:0]         win_3,
  output logic [7:0]         win_4,
  output logic [7:0]         win_5,
  output logic [7:0]         win_6,
  output logic [7:0]         win_7,
  output logic [7:0]         win_8,
  output logic               frame_done
);

  localparam int          PW      = $clog2(ROW);
  localparam logic [31:0] c_LAT   = 32'(ROW + 1);
  localparam logic [31:0] c_NM1   = 32'(ROW * COL - 1);
  localparam logic [31:0] c_FEND  = 32'(ROW * COL + ROW);
  localparam logic signed [33:0] c_N34 = 34'(ROW * COL);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t          r_state;
  logic [31:0]     r_in_cnt;
  logic [PW-1:0]   r_ptr;
  logic [7:0]      r_lb0 [ROW];
  logic [7:0]      r_lb1 [ROW];
  logic [7:0]      r_a0, r_a1, r_b0, r_b1, r_c0, r_c1;
  logic [7:0]      r_win [9];

  logic            w_acc, w_shift, w_emit;
  logic [31:0]     w_q, w_p;
  logic [7:0]      w_new, w_l1, w_l2;
  logic [7:0]      w_tap [9];
  logic signed [33:0] w_s [9];
  logic [8:0]      w_m;

  assign in_ready = (r_state != S_FLUSH);
  assign w_acc    = in_valid & in_ready;
  assign w_shift  = (r_state == S_FLUSH) | (w_acc & (in_sof | (r_state == S_RUN)));
  assign w_q      = (w_acc & in_sof) ? 32'd0 : r_in_cnt;
  assign w_p      = w_q - c_LAT;
  assign w_emit   = w_shift & (w_q >= c_LAT);
  assign w_new    = (r_state == S_FLUSH) ? 8'd0 : in_data;
  assign w_l1     = r_lb0[r_ptr];
  assign w_l2     = r_lb1[r_ptr];

  // Taps as they will stand once the incoming sample has been shifted in.
  assign w_tap[8] = w_new;
  assign w_tap[7] = r_a0;
  assign w_tap[6] = r_a1;
  assign w_tap[5] = w_l1;
  assign w_tap[4] = r_b0;
  assign w_tap[3] = r_b1;
  assign w_tap[2] = w_l2;
  assign w_tap[1] = r_c0;
  assign w_tap[0] = r_c1;

  genvar k;
  generate
    for (k = 0; k < 9; k++) begin : g_tap
      localparam logic signed [33:0] c_OFF = 34'((k / 3 - 1) * ROW + (k % 3 - 1));
      assign w_s[k] = $signed({2'b00, w_p}) + c_OFF;
      assign w_m[k] = w_s[k][33] | (w_s[k] >= c_N34);
    end
  endgenerate

  assign win_0 = r_win[0];
  assign win_1 = r_win[1];
  assign win_2 = r_win[2];
  assign win_3 = r_win[3];
  assign win_4 = r_win[4];
  assign win_5 = r_win[5];
  assign win_6 = r_win[6];
  assign win_7 = r_win[7];
  assign win_8 = r_win[8];

  always_ff @(posedge clk) begin
    if (w_shift) begin
      r_lb0[r_ptr] <= w_new;
      r_lb1[r_ptr] <= w_l1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_in_cnt   <= '0;
      r_ptr      <= '0;
      r_a0       <= '0;
      r_a1       <= '0;
      r_b0       <= '0;
      r_b1       <= '0;
      r_c0       <= '0;
      r_c1       <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      pixel      <= '0;
      for (int i = 0; i < 9; i++) r_win[i] <= '0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (w_shift) begin
        r_a0  <= w_new;
        r_a1  <= r_a0;
        r_b0  <= w_l1;
        r_b1  <= r_b0;
        r_c0  <= w_l2;
        r_c1  <= r_c0;
        r_ptr <= (r_ptr == PW'(ROW - 1)) ? '0 : r_ptr + 1'b1;
      end
      if (w_emit) begin
        out_valid  <= 1'b1;
        pixel      <= w_p;
        frame_done <= (w_p == c_NM1);
        for (int i = 0; i < 9; i++) r_win[i] <= w_m[i] ? 8'd0 : w_tap[i];
      end
      // A start-of-frame sample restarts indexing from any accepting state.
      if (w_acc & in_sof) begin
        r_in_cnt <= 32'd1;
        r_state  <= S_RUN;
      end else begin
        case (r_state)
          S_RUN: begin
            if (w_acc) begin
              r_in_cnt <= r_in_cnt + 32'd1;
              if (r_in_cnt == c_NM1) r_state <= S_FLUSH;
            end
          end
          S_FLUSH: begin
            if (r_in_cnt == c_FEND) begin
              r_in_cnt <= '0;
              r_state  <= S_IDLE;
            end else begin
              r_in_cnt <= r_in_cnt + 32'd1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_median_window_gen.sv
// tb_median_window_gen: directed self-checking bench for median_window_gen (ROW=4, COL=3).
`timescale 1ns/1ps
`default_nettype none

module tb_median_window_gen;
  localparam int ROW = 4;
  localparam int COL = 3;
  localparam int N   = ROW * COL;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_sof = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic in_ready, out_valid, frame_done;
  logic signed [31:0] pixel;
  logic [7:0] win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8;
  logic [71:0] w_obs;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          pix;
    logic [71:0] w;
    logic        fd;
    logic        pre;
    logic        fl;
  } rec_t;
  rec_t q[$];

  median_window_gen #(.ROW(ROW), .COL(COL)) dut (
    .clk(clk), .rst_n(rst_n), .in_sof(in_sof), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .pixel(pixel),
    .win_0(win_0), .win_1(win_1), .win_2(win_2), .win_3(win_3), .win_4(win_4),
    .win_5(win_5), .win_6(win_6), .win_7(win_7), .win_8(win_8), .frame_done(frame_done)
  );

  assign w_obs = {win_8, win_7, win_6, win_5, win_4, win_3, win_2, win_1, win_0};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] exp_win(input int p, input int off);
    logic [71:0] r;
    int s;
    r = '0;
    for (int k = 0; k < 9; k++) begin
      s = p + (k / 3 - 1) * ROW + (k % 3 - 1);
      r[8*k +: 8] = (s < 0 || s >= N) ? 8'd0 : 8'(s + off);
    end
    return r;
  endfunction

  task automatic tick();
    rec_t r;
    logic fl, pre;
    fl  = !in_ready;
    pre = (in_valid && in_ready) || fl;
    @(posedge clk);
    #1;
    if (out_valid) begin
      r.pix = pixel; r.w = w_obs; r.fd = frame_done; r.pre = pre; r.fl = fl;
      q.push_back(r);
    end
  endtask

  task automatic send(input int d, input logic sof);
    in_valid = 1'b1; in_sof = sof; in_data = 8'(d);
    tick();
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_frame(input int off);
    int nfl;
    nfl = 0;
    chk("nout", 72'(q.size()), 72'(N));
    for (int i = 0; i < q.size() && i < N; i++) begin
      chk("pix_seq", 72'(q[i].pix), 72'(i));
      chk("win", q[i].w, exp_win(i, off));
      chk("fd", 72'(q[i].fd), 72'(i == N - 1));
      chk("ov_after_acc", 72'(q[i].pre), 72'd1);
      if (q[i].fl) begin
        chk("flush_pix", 72'(q[i].pix), 72'(N - ROW - 1 + nfl));
        nfl++;
      end
    end
    chk("nflush", 72'(nfl), 72'(ROW + 1));
  endtask

  task automatic frame(input int off, input int gap);
    for (int i = 0; i < N; i++) begin
      send(i + off, i == 0);
      if (gap != 0) idle(1);
    end
    idle(8);
  endtask

  initial begin
    #12;
    chk("rst_ov", 72'(out_valid), 72'd0);
    chk("rst_rdy", 72'(in_ready), 72'd1);
    chk("rst_pix", 72'(pixel), 72'd0);
    chk("rst_win", w_obs, 72'd0);
    chk("rst_fd", 72'(frame_done), 72'd0);
    rst_n = 1'b1;

    // Back-to-back frame with hand-checked windows at both ends
    q.delete();
    for (int i = 0; i < N; i++) begin
      send(i + 10, i == 0);
      if (i == 4) chk("ov_early", 72'(out_valid), 72'd0);
      if (i == 5) begin
        chk("first_ov", 72'(out_valid), 72'd1);
        chk("first_pix", 72'(pixel), 72'd0);
        chk("pix0_win", w_obs, 72'h0F0E0D0B0A00000000);
      end
    end
    chk("rdy_flush", 72'(in_ready), 72'd0);
    idle(8);
    chk("fd_after", 72'(frame_done), 72'd0);
    chk("rdy_after", 72'(in_ready), 72'd1);
    if (q.size() >= N) chk("pix11_win", q[N-1].w, 72'h000000001514121110);
    check_frame(10);

    // in_valid toggling every cycle
    q.delete();
    frame(10, 1);
    check_frame(10);

    // samples without sof in IDLE are dropped
    q.delete();
    for (int i = 0; i < 4; i++) send(i + 30, 1'b0);
    idle(2);
    chk("drop_nout", 72'(q.size()), 72'd0);
    frame(40, 0);
    check_frame(40);

    // sof at index 7 aborts without flushing
    q.delete();
    for (int i = 0; i < 7; i++) send(i + 10, i == 0);
    chk("pre_abort_nout", 72'(q.size()), 72'd2);
    q.delete();
    send(50, 1'b1);
    chk("abort_rdy", 72'(in_ready), 72'd1);
    chk("abort_ov", 72'(out_valid), 72'd0);
    for (int i = 1; i < N; i++) begin
      send(i + 50, 1'b0);
      if (i == 4) chk("abort_nout4", 72'(q.size()), 72'd0);
      if (i == 5) chk("abort_nout5", 72'(q.size()), 72'd1);
    end
    idle(8);
    check_frame(50);

    // asynchronous reset in the middle of FLUSH
    for (int i = 0; i < N; i++) send(i + 10, i == 0);
    idle(2);
    chk("pre_rst_flush", 72'(in_ready), 72'd0);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", 72'(out_valid), 72'd0);
    chk("mid_rst_rdy", 72'(in_ready), 72'd1);
    chk("mid_rst_pix", 72'(pixel), 72'd0);
    chk("mid_rst_win", w_obs, 72'd0);
    chk("mid_rst_fd", 72'(frame_done), 72'd0);
    #3 rst_n = 1'b1;
    q.delete();
    for (int i = 0; i < 8; i++) send(i + 1, 1'b0);
    chk("post_rst_nout", 72'(q.size()), 72'd0);
    frame(60, 0);
    check_frame(60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
